// File: rtl/booth_mult8.sv
// booth_mult8: sequential 8x8 signed radix-2 Booth multiplier.
// Ports: clk, rst_n, start, a, b -> product[15:0], busy, done.
module booth_mult8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_d;

  logic [7:0]  acc;
  logic [7:0]  q;
  logic        q1;
  logic [7:0]  m;
  logic [3:0]  cnt;

  logic        opcode;
  logic        use_as;
  logic [7:0]  as_sum;
  logic        as_ovf;
  logic [7:0]  sum;
  logic        sin;
  logic        last;

  assign last = (cnt == 4'd7);

  // Booth recode of {Q[0],Q_1}
  always_comb begin
    opcode = 1'b0;
    use_as = 1'b0;
    unique case (1'b1)
      ({q[0], q1} == 2'b01): begin
        opcode = 1'b0;
        use_as = 1'b1;
      end
      ({q[0], q1} == 2'b10): begin
        opcode = 1'b1;
        use_as = 1'b1;
      end
      default: begin
        opcode = 1'b0;
        use_as = 1'b0;
      end
    endcase
  end

  // 8-bit ripple add/subtract stage, cin = opcode
  always_comb begin : addsub
    logic [7:0] bx;
    logic       cy;
    logic       c7;
    bx     = m ^ {8{opcode}};
    cy     = opcode;
    c7     = 1'b0;
    as_sum = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) c7 = cy;
      as_sum[i] = acc[i] ^ bx[i] ^ cy;
      cy = (acc[i] & bx[i]) | (cy & (acc[i] ^ bx[i]));
    end
    as_ovf = cy ^ c7;
  end

  // Overflow-corrected sign keeps the 9-bit result exact (M = -128)
  always_comb begin
    sum = acc;
    sin = acc[7];
    if (use_as) begin
      sum = as_sum;
      sin = as_sum[7] ^ as_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= 8'h00;
      q       <= 8'h00;
      q1      <= 1'b0;
      m       <= 8'h00;
      cnt     <= 4'd0;
      product <= 16'h0000;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            m   <= a;
            q   <= b;
            acc <= 8'h00;
            q1  <= 1'b0;
            cnt <= 4'd0;
          end
        end
        CALC: begin
          acc <= {sin, sum[7:1]};
          q   <= {sum[0], q[7:1]};
          q1  <= q[0];
          cnt <= cnt + 4'd1;
          if (last)
            product <= {sin, sum[7:1],
                        sum[0], q[7:1]};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult8.sv
// tb_booth_mult8: vector table, corner sequences and random
// operands checked against signed integer multiplication.
module tb_booth_mult8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int checks;
  int failures;
  int ndone;

  booth_mult8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (done === 1'b1) ndone++;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] model(
      input logic [7:0] x, input logic [7:0] y);
    int px;
    int py;
    px = $signed(x);
    py = $signed(y);
    return 16'(px * py);
  endfunction

  // Start a multiply, wait bounded for done, check latency
  task automatic mult(input logic [7:0] ia,
                      input logic [7:0] ib,
                      input logic [15:0] exp,
                      input string nm);
    int n;
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    n = 1;
    while (!done && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'd9);
    chk({nm, "_prod"}, 32'(product), 32'(exp));
    @(posedge clk);
    #1;
    chk({nm, "_idle"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    int d0;
    int n;
    logic [7:0] ra;
    logic [7:0] rb;
    checks   = 0;
    failures = 0;
    ndone    = 0;
    start    = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    rst_n    = 1'b0;
    vt[0] = '{8'h03, 8'h05, 16'h000F};
    vt[1] = '{8'hFD, 8'h07, 16'hFFEB};
    vt[2] = '{8'h80, 8'h80, 16'h4000};
    vt[3] = '{8'h7F, 8'h80, 16'hC080};
    vt[4] = '{8'h00, 8'h55, 16'h0000};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prod", 32'(product), 32'd0);
    chk("rst_flags", 32'({busy, done}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      mult(vt[i].a, vt[i].b, vt[i].p,
           $sformatf("vec%0d", i));

    // start pulses during CALC and DONE are ignored
    d0 = ndone;
    @(negedge clk);
    a = 8'd6;
    b = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a = 8'd1;
    b = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 5;
    while (!done && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("busy_lat", 32'(n), 32'd9);
    chk("busy_prod", 32'(product), 32'h002A);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("done_start_busy", 32'(busy), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("done_start_prod", 32'(product), 32'h002A);
    chk("done_pulses", 32'(ndone - d0), 32'd1);

    // reset during iteration 4
    d0 = ndone;
    @(negedge clk);
    a = 8'd9;
    b = 8'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_prod", 32'(product), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_nodone", 32'(ndone - d0), 32'd0);
    mult(8'd2, 8'hFE, 16'hFFFC, "post_abort");

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      mult(ra, rb, model(ra, rb),
           $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
